// File: rtl/vt_seq_detect_param.sv
// vt_seq_detect_param: parametrised serial pattern detector with Mealy and registered match flags
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module vt_seq_detect_param #(
  parameter int SEQ_LEN = 6,
  parameter logic [SEQ_LEN-1:0] SEQ = 6'b100110,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_SI,
  input  logic               i_pat_ld,
  input  logic [SEQ_LEN-1:0] i_pat,
  input  logic               i_clr_cnt,
  output logic               o_f,
  output logic               o_f_r,
  output logic [CNT_W-1:0]   o_cnt
);
  localparam int FW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN - 1);
  logic [SEQ_LEN-1:0] pat_q, pat_d, win;
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic f_r_q, f_r_d, match;
  always_comb begin
    win = {hist_q, i_SI};
    match = i_en && fill_q == FULL && win == pat_q;
    pat_d = i_pat_ld ? i_pat : pat_q;
    hist_d = i_en ? win[SEQ_LEN-2:0] : hist_q;
    fill_d = (i_pat_ld || (match && !OVERLAP)) ? '0 :
             (i_en && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    f_r_d = match;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      pat_q <= SEQ;
      hist_q <= '0;
      fill_q <= '0;
      f_r_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      f_r_q <= f_r_d;
    end
  assign o_f = match;
  assign o_f_r = f_r_q;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clr_cnt ? '0 : (match && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = i_clr_cnt;
  assign o_cnt = '0;
`endif
endmodule
